// File: rtl/uart_tx_if.sv
// Parallel-side port bundle of uart_tx: word handshake plus transmitter status.
interface uart_tx_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    uart_tx_valid;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_tx_ready;
    logic                    uart_tx_busy;

    // valid/ready: a word moves on every clk edge where both are high; ready never
    // depends on valid, and data is don't-care whenever valid is low.
    modport master (
        output uart_tx_valid,
        output uart_tx_data,
        input  uart_tx_ready,
        input  uart_tx_busy
    );

    modport slave (
        input  uart_tx_valid,
        input  uart_tx_data,
        output uart_tx_ready,
        output uart_tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter (start + data LSB-first + optional parity + stop) with a one-word
// holding buffer for gap-free back-to-back frames. Parity bit enabled by UART_TX_PARITY_EN.
module uart_tx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 27_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus,
    output logic       uart_txd,
    output logic [2:0] state_dbg
);
    localparam int BIT_P          = 1_000_000_000 / BIT_RATE;
    localparam int CLK_P          = 1_000_000_000 / CLK_HZ;
    localparam int CYCLES_PER_BIT = BIT_P / CLK_P;
    localparam int CW             = 1 + $clog2(CYCLES_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'(PAYLOAD_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    if (PAYLOAD_BITS < 1 || PAYLOAD_BITS > 8) begin : g_bad_payload
        $error("uart_tx: PAYLOAD_BITS must be 1..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1..2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d, shift_nx;
    logic [PAYLOAD_BITS-1:0] buf_q;
    logic                    buf_full_q;
    logic                    txd_q, txd_d;
    logic                    load;

`ifdef UART_TX_PARITY_EN
    logic par_q;

    // Parity is fixed when the word leaves the buffer, so it is ready by the last data bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= (^buf_q) ^ 1'(PARITY_ODD);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            // load only happens with the buffer full, accept only with it empty
            if (load) begin
                buf_full_q <= 1'b0;
            end else if (bus.uart_tx_valid && !buf_full_q) begin
                buf_q      <= bus.uart_tx_data;
                buf_full_q <= 1'b1;
            end
        end
    end

    // txd_d is the line level for the state being entered, so the pin is a pure flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        load     = 1'b0;
        shift_nx = shift_q >> 1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                txd_d = 1'b1;
                if (buf_full_q) begin
                    load    = 1'b1;
                    shift_d = buf_q;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_nx;
                        txd_d   = shift_nx[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q != STOP_LAST) begin
                        bit_d = bit_q + 1'b1;
                    end else if (buf_full_q) begin
                        load    = 1'b1;
                        shift_d = buf_q;
                        bit_d   = '0;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        bit_d   = '0;
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign bus.uart_tx_ready = !buf_full_q;
    assign bus.uart_tx_busy  = (state_q != IDLE) || buf_full_q;
    assign uart_txd          = txd_q;
    assign state_dbg         = state_q;
endmodule
